// File: rtl/branch_ctrl.sv
// Branch control stage upstream of the PC: decodes branch/halt instructions,
// holds the compare flag, a loadable branch-target table and an executed-instruction count.
module branch_ctrl #(
    parameter int PC_W      = 11,
    parameter int INST_W    = 9,
    parameter int LUT_DEPTH = 32,
    parameter int CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PC_W-1:0]   ProgCtr,
    input  logic [INST_W-1:0] Instruction,
    input  logic              AluFlag,
    input  logic              FlagWrite,
    input  logic              LutWe,
    input  logic [4:0]        LutAddr,
    input  logic [PC_W-1:0]   LutData,
    output logic              BranchEn,
    output logic              BranchOnFlag,
    output logic [PC_W-1:0]   Target,
    output logic              FlagReg,
    output logic              Done,
    output logic [CNT_W-1:0]  InstCount,
    output logic              DbgState
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [3:0]        OP_BRT   = 4'b1100;
    localparam logic [3:0]        OP_BRF   = 4'b1101;
    localparam logic [3:0]        OP_JMP   = 4'b1110;
    localparam logic [INST_W-1:0] INST_HLT = '1;

    state_t             state_q;
    logic               flag_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [PC_W-1:0]    lut_q [LUT_DEPTH];

    logic [3:0]         opcode;
    logic [4:0]         operand;
    logic               is_halt;
    logic [PC_W-1:0]    lut_rd;

    assign opcode  = Instruction[8:5];
    assign operand = Instruction[4:0];
    assign is_halt = (Instruction == INST_HLT);
    assign lut_rd  = lut_q[operand];

    // Saturating count: stays at all-ones instead of wrapping.
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        BranchEn     = 1'b0;
        BranchOnFlag = 1'b0;
        Target       = lut_rd;
        if (state_q == ST_HALTED || is_halt) begin
            // Self-jump on the current PC; flag-equal polarity makes it unconditional.
            BranchEn     = 1'b1;
            BranchOnFlag = flag_q;
            Target       = ProgCtr;
        end else begin
            case (opcode)
                OP_BRT: begin
                    BranchEn     = 1'b1;
                    BranchOnFlag = 1'b1;
                end
                OP_BRF: begin
                    BranchEn     = 1'b1;
                    BranchOnFlag = 1'b0;
                end
                OP_JMP: begin
                    BranchEn     = 1'b1;
                    BranchOnFlag = flag_q;
                end
                default: begin
                    BranchEn     = 1'b0;
                    BranchOnFlag = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (Start) begin
            state_q <= ST_RUN;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            if (FlagWrite) begin
                flag_q <= AluFlag;
            end
            cnt_q <= cnt_d;
            if (is_halt) begin
                state_q <= ST_HALTED;
                done_q  <= 1'b1;
            end
        end
    end

    // Table writes are independent of the FSM; reads in the write cycle see the old entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (LutWe) begin
            lut_q[LutAddr] <= LutData;
        end
    end

    assign FlagReg   = flag_q;
    assign Done      = done_q;
    assign InstCount = cnt_q;
    assign DbgState  = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed program sequences, a behavioural model compared
// on every falling edge, and hand-computed literal checks at key points.
module tb_branch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [10:0] ProgCtr = '0;
    logic [8:0]  Instruction = '0;
    logic        AluFlag = 1'b0;
    logic        FlagWrite = 1'b0;
    logic        LutWe = 1'b0;
    logic [4:0]  LutAddr = '0;
    logic [10:0] LutData = '0;
    logic        BranchEn;
    logic        BranchOnFlag;
    logic [10:0] Target;
    logic        FlagReg;
    logic        Done;
    logic [15:0] InstCount;
    logic        DbgState;

    int checks = 0;
    int failures = 0;

    branch_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgCtr(ProgCtr),
        .Instruction(Instruction), .AluFlag(AluFlag), .FlagWrite(FlagWrite),
        .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
        .BranchEn(BranchEn), .BranchOnFlag(BranchOnFlag), .Target(Target),
        .FlagReg(FlagReg), .Done(Done), .InstCount(InstCount), .DbgState(DbgState)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    logic        m_halted = 1'b0;
    logic        m_flag = 1'b0;
    int          m_cnt = 0;
    logic [10:0] m_lut [32] = '{default: '0};
    logic        exp_en;
    logic        exp_bof;
    logic [10:0] exp_tgt;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_halted <= 1'b0;
            m_flag   <= 1'b0;
            m_cnt    <= 0;
            for (int i = 0; i < 32; i++) m_lut[i] <= '0;
        end else begin
            if (LutWe) m_lut[LutAddr] <= LutData;
            if (Start) begin
                m_halted <= 1'b0;
                m_flag   <= 1'b0;
                m_cnt    <= 0;
            end else if (!m_halted) begin
                if (FlagWrite) m_flag <= AluFlag;
                m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                if (Instruction == 9'h1FF) m_halted <= 1'b1;
            end
        end
    end

    always_comb begin
        exp_en  = 1'b0;
        exp_bof = 1'b0;
        exp_tgt = m_lut[Instruction[4:0]];
        if (m_halted || Instruction == 9'h1FF) begin
            exp_en  = 1'b1;
            exp_bof = m_flag;
            exp_tgt = ProgCtr;
        end else begin
            case (Instruction[8:5])
                4'hC: begin exp_en = 1'b1; exp_bof = 1'b1; end
                4'hD: begin exp_en = 1'b1; exp_bof = 1'b0; end
                4'hE: begin exp_en = 1'b1; exp_bof = m_flag; end
                default: begin exp_en = 1'b0; exp_bof = 1'b0; end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        check("model_branch_en", 32'(BranchEn), 32'(exp_en));
        check("model_branch_on_flag", 32'(BranchOnFlag), 32'(exp_bof));
        check("model_target", 32'(Target), 32'(exp_tgt));
        check("model_flag_reg", 32'(FlagReg), 32'(m_flag));
        check("model_done", 32'(Done), 32'(m_halted));
        check("model_state", 32'(DbgState), 32'(m_halted));
        check("model_inst_count", 32'(InstCount), 32'(m_cnt));
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #1 Reset = 1'b1;
        #1;
        check("rst_flag", 32'(FlagReg), 32'h0);
        check("rst_done", 32'(Done), 32'h0);
        check("rst_count", 32'(InstCount), 32'h0);
        check("rst_nop_branch_en", 32'(BranchEn), 32'h0);
        check("rst_target", 32'(Target), 32'h0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        #1;

        // Load LUT[3] while presenting JMP to it: same-cycle read sees the old entry.
        LutWe = 1'b1; LutAddr = 5'd3; LutData = 11'h040;
        Instruction = 9'h1C3; ProgCtr = 11'd10;
        #1;
        check("lut_same_cycle_old", 32'(Target), 32'h0);
        check("jmp_branch_en", 32'(BranchEn), 32'h1);
        tick();
        LutAddr = 5'd5; LutData = 11'h123;
        #1;
        check("jmp_target", 32'(Target), 32'h040);
        check("jmp_bof_eq_flag", 32'(BranchOnFlag), 32'(FlagReg));
        tick();
        LutWe = 1'b0;

        // BRT with FlagWrite in the same cycle uses the old flag.
        Instruction = 9'h183; FlagWrite = 1'b1; AluFlag = 1'b1;
        #1;
        check("brt_fw_bof", 32'(BranchOnFlag), 32'h1);
        check("brt_fw_old_flag", 32'(FlagReg), 32'h0);
        check("brt_fw_not_taken", 32'(BranchOnFlag == FlagReg), 32'h0);
        tick();
        FlagWrite = 1'b0;
        #1;
        check("flag_set", 32'(FlagReg), 32'h1);
        check("brt_taken", 32'(BranchOnFlag == FlagReg), 32'h1);
        check("brt_target", 32'(Target), 32'h040);
        tick();

        // BRF with flag set falls through, then taken once flag clears.
        Instruction = 9'h1A5;
        #1;
        check("brf_bof", 32'(BranchOnFlag), 32'h0);
        check("brf_not_taken", 32'(BranchOnFlag == FlagReg), 32'h0);
        tick();
        Instruction = 9'h000; FlagWrite = 1'b1; AluFlag = 1'b0;
        #1;
        check("nop_branch_en", 32'(BranchEn), 32'h0);
        tick();
        FlagWrite = 1'b0; Instruction = 9'h1A5;
        #1;
        check("brf_taken", 32'(BranchOnFlag == FlagReg), 32'h1);
        check("brf_target", 32'(Target), 32'h123);
        tick();

        // New program: 5 NOPs then HALT at PC 6.
        Start = 1'b1; Instruction = 9'h000;
        tick();
        Start = 1'b0;
        #1;
        check("start_count_zero", 32'(InstCount), 32'h0);
        for (int i = 0; i < 5; i++) begin
            ProgCtr = 11'(i + 1);
            FlagWrite = (i == 2);
            AluFlag = 1'b1;
            tick();
        end
        FlagWrite = 1'b0;
        #1;
        check("five_nops_count", 32'(InstCount), 32'd5);
        ProgCtr = 11'd6; Instruction = 9'h1FF;
        #1;
        check("halt_branch_en", 32'(BranchEn), 32'h1);
        check("halt_target_pc", 32'(Target), 32'd6);
        check("halt_not_done_yet", 32'(Done), 32'h0);
        tick();
        Instruction = 9'h1C3;
        LutWe = 1'b1; LutAddr = 5'd7; LutData = 11'h2AB;
        #1;
        check("halted_done", 32'(Done), 32'h1);
        check("halted_count", 32'(InstCount), 32'd6);
        check("halted_target_pc", 32'(Target), 32'd6);
        tick();
        LutWe = 1'b0;
        repeat (3) tick();
        check("halted_count_hold", 32'(InstCount), 32'd6);
        check("halted_flag_hold", 32'(FlagReg), 32'h1);
        check("halted_branch_en", 32'(BranchEn), 32'h1);

        // Two-cycle Start in HALTED; FlagWrite must be ignored meanwhile.
        Start = 1'b1; FlagWrite = 1'b1; AluFlag = 1'b1;
        repeat (2) tick();
        Start = 1'b0; FlagWrite = 1'b0; Instruction = 9'h1C7;
        #1;
        check("restart_count", 32'(InstCount), 32'h0);
        check("restart_flag", 32'(FlagReg), 32'h0);
        check("restart_done", 32'(Done), 32'h0);
        check("restart_state_run", 32'(DbgState), 32'h0);
        check("lut_write_in_halt", 32'(Target), 32'h2AB);
        tick();
        Instruction = 9'h000; FlagWrite = 1'b1; AluFlag = 1'b1;
        tick();
        FlagWrite = 1'b0; Instruction = 9'h1C3;
        #1;
        check("run_count", 32'(InstCount), 32'd2);
        check("run_flag", 32'(FlagReg), 32'h1);

        // Asynchronous reset mid-cycle clears state and table at once.
        #1 Reset = 1'b1;
        #1;
        check("async_rst_flag", 32'(FlagReg), 32'h0);
        check("async_rst_count", 32'(InstCount), 32'h0);
        check("async_rst_done", 32'(Done), 32'h0);
        check("async_rst_lut", 32'(Target), 32'h0);
        tick();
        Reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Decode-side control stage that sits directly upstream of the program counter.
- Inspects the instruction fetched at the current ProgCtr and keeps the compare flag register.
- Drives BranchEn, BranchOnFlag and Target into the PC block.
- Owns a loadable 32-entry branch-target lookup table, a RUN/HALTED state machine and an executed-instruction counter.
- Asserts Done so the test harness can sequence programs with Start.

Parameters:
- PC_W, 11, program counter and target width.
- INST_W, 9, instruction width.
- LUT_DEPTH, 32, number of branch-target entries; index is Instruction[4:0].
- CNT_W, 16, executed-instruction counter width.

Ports:
- Clk  in  1  system clock; all state changes on the posedge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Start  in  1  begin next program; held high while the PC block holds.
- ProgCtr  in  PC_W  current PC from the PC block.
- Instruction  in  INST_W  instruction-memory word at ProgCtr, combinational.
- AluFlag  in  1  compare result from the ALU for the current instruction.
- FlagWrite  in  1  current instruction updates the flag.
- LutWe  in  1  target-LUT write enable.
- LutAddr  in  5  target-LUT write address.
- LutData  in  PC_W  target-LUT write data.
- BranchEn  out  1  to PC block; branch requested this cycle.
- BranchOnFlag  out  1  to PC block; the PC block branches when its flag input equals this value.
- Target  out  PC_W  to PC block; absolute jump address.
- FlagReg  out  1  registered flag; drives the PC block's branch_flag.
- Done  out  1  high in HALTED.
- InstCount  out  CNT_W  instructions executed since the last Start or Reset.

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state=RUN, FlagReg=0, InstCount=0;
  - all LUT entries=0;
  - therefore Done=0 and Target=0.
- Opcode field is Instruction[8:5]; operand is Instruction[4:0].
  - 1100 BRT: branch if FlagReg==1.
  - 1101 BRF: branch if FlagReg==0.
  - 1110 JMP: unconditional.
  - 9'h1FF HALT.
  - All else: non-branch.
- Outputs are combinational from Instruction, FlagReg and state (zero-latency). The PC block samples them on the same posedge.
- In RUN:
  - BRT: BranchEn=1, BranchOnFlag=1, Target=LUT[operand].
  - BRF: BranchEn=1, BranchOnFlag=0, Target=LUT[operand].
  - JMP: BranchEn=1, BranchOnFlag=FlagReg (always matches), Target=LUT[operand].
  - Other instructions: BranchEn=0, BranchOnFlag=0, Target=LUT[operand], which is don't-care but deterministic.
- HALT in RUN acts as a self-jump: BranchEn=1, BranchOnFlag=FlagReg, Target=ProgCtr. Next state is HALTED.
- In HALTED, Instruction is ignored and outputs hold the PC: BranchEn=1, BranchOnFlag=FlagReg, Target=ProgCtr. Done=1.
- Start (sampled on the posedge; Reset has priority):
  - Start=1 in any state: next state=RUN, FlagReg<=0, InstCount<=0.
  - While Start=1, FlagWrite is ignored and InstCount does not count.
  - Outputs remain combinational; the PC block holds on Start.
- FlagReg <= AluFlag on a posedge when state==RUN && FlagWrite && !Start.
  - A branch in the same cycle as FlagWrite uses the old FlagReg value.
- InstCount increments by 1 on each posedge in RUN with Start=0, including the HALT instruction itself. It saturates at 2^CNT_W-1 (no wrap).
- LUT writes:
  - Take effect on the posedge when LutWe=1, in any state, including while Start=1.
  - A same-cycle read of the address being written returns the old value.
- Reset asserted mid-program clears everything immediately, without waiting for a clock edge.
- HALTED remains until Start or Reset.

Test Plan:
- Reset → FlagReg=0, Done=0, InstCount=0, BranchEn=0 for a NOP (9'h000); Target=0 for operand 0.
- Load LUT[3]=11'h040, then present JMP (9'h1C3) → BranchEn=1, Target=0x040, BranchOnFlag==FlagReg.
- FlagWrite=1 with AluFlag=1 plus BRT 9'h183 in the same cycle → that cycle BranchOnFlag=1 with FlagReg still 0 (PC block falls through). Next cycle FlagReg=1; a repeated BRT → PC block branches to LUT[3].
- BRF 9'h1A5 with FlagReg=1 → BranchOnFlag=0, so the PC block does not branch. After FlagReg is cleared, it branches to LUT[5].
- Run 5 NOPs then HALT at ProgCtr=6 → Done=1 the next cycle, Target=ProgCtr, BranchEn=1 on every cycle. InstCount=6, then holds while HALTED.
- In HALTED, pulse Start for 2 cycles → InstCount=0, FlagReg=0, state=RUN, Done=0. Assert Reset mid-run → all outputs return to reset values immediately.
